pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the team's 4-bit ripple carry adder. It adds or subtracts two WIDTH-bit operands, split into STAGES ripple slices with a register stage after each slice. A valid/ready handshake and global stall let it sit directly in datapaths that need throughput of one operation per cycle at higher clock rates than a single long ripple chain allows.

Parameters:
WIDTH, 16, operand and result width in bits; must be divisible by STAGES
STAGES, 4, number of pipeline slices (1..WIDTH); latency in cycles; SLICE = WIDTH/STAGES bits per slice

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  A/B/Cin/Sub present a transaction
in_ready  output  1  pipeline can accept this cycle
A  input  WIDTH  operand A (unsigned or two's complement)
B  input  WIDTH  operand B
Cin  input  1  carry-in, used only when Sub=0
Sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1; Cin ignored)
out_valid  output  1  Sum/Cout/Ovf hold a completed result
out_ready  input  1  downstream accepts result this cycle
Sum  output  WIDTH  result modulo 2^WIDTH
Cout  output  1  carry-out of MSB; for Sub=1, 1 = no borrow
Ovf  output  1  signed overflow

Behaviour:
- Reset (async assert, sync release to next edge): all stage valid bits 0, out_valid=0, Sum=0, Cout=0, Ovf=0, all inter-stage carry/skew registers 0.
- advance = out_ready | ~out_valid; in_ready = advance (combinational). Whole pipeline shifts only when advance=1. Bubbles are not collapsed.
- Accept: in_valid & in_ready. Stage 0 registers: slice 0 sum bits, slice 0 carry, remaining operand slices (B already conditionally inverted), MSB sign info, and the valid bit.
- Stage k (1..STAGES-1) adds slice k using the registered carry from stage k-1. Lower result slices are carried forward in de-skew registers; upper operand slices are carried forward in skew registers.
- Latency is exactly STAGES cycles from accept to out_valid, assuming no stall. Throughput is 1 per cycle. Results leave in issue order.
- Stall (out_valid=1, out_ready=0): every register holds, Sum/Cout/Ovf stay stable, and in_ready=0. An input presented during a stall is not accepted and must be held by upstream.
- Bop = Sub ? ~B : B; carry-in to slice 0 = Sub ? 1 : Cin.
- Ovf = (A[MSB] == Bop[MSB]) & (Sum[MSB] != A[MSB]). Compute it in the final stage from the registered A[MSB]/Bop[MSB].
- Invalid stages still shift. Their data is don't-care but must not be exposed: Sum/Cout/Ovf change only on an edge where a valid result enters the output stage.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops asynchronously. Nothing stale appears after release.
- STAGES=1: a single ripple chain with output registers; latency 1.
- WIDTH % STAGES != 0: elaboration error via a generate-time check.

Decomposition:
- Shared package (adder_pkg): SLICE width computation, overflow helper function, parameter-check constant.
- Sub-module: adder_slice, a parametrised SLICE-bit ripple chain of the existing full_adder cells (a, b, cin -> sum, cout). It is purely combinational and instantiated STAGES times in a generate loop. Pipeline, skew and handshake registers live in pipelined_adder.

Test Plan:
All scenarios use WIDTH=16, STAGES=4.
- Add: A=0xFFFF, B=0x0001, Cin=0, Sub=0, out_ready=1 -> exactly 4 cycles later out_valid=1, Sum=0x0000, Cout=1, Ovf=0.
- Carry across slices: A=0x0FFF, B=0x0000, Cin=1 -> Sum=0x1000, Cout=0, Ovf=0. Then A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1.
- Subtract: A=0x8000, B=0x0001, Sub=1, Cin=1 (ignored) -> Sum=0x7FFF, Cout=1, Ovf=1. Then A=0x0003, B=0x0005, Sub=1 -> Sum=0xFFFE, Cout=0, Ovf=0.
- Back-to-back: 3 accepts on consecutive cycles (1+2, 3+4, 5+6), out_ready=1 -> out_valid high for 3 consecutive cycles starting 4 cycles after first accept, Sum = 3, 7, 11 in order.
- Backpressure: first result arrives with out_ready=0 for 3 cycles -> Sum/Cout/Ovf constant and in_ready=0 during the stall. On release, all queued results emerge in order with none lost or duplicated.
- Reset mid-operation: 2 transactions in flight, rst pulsed high for 1 cycle -> out_valid=0 and Sum=0 immediately. No out_valid for the next 4 cycles without new input, and a fresh 0x0001+0x0001 afterwards returns 0x0002 in 4 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice sizing, parameter sanity
// check and the signed-overflow rule.
package adder_pkg;

  function automatic int slice_width(input int width, input int stages);
    if (stages > 32'sd0) begin
      return width / stages;
    end else begin
      return 32'sd1;
    end
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 32'sd1) && (stages <= width) && ((width % stages) == 32'sd0);
  endfunction

  // Overflow when both addends share a sign and the result sign differs.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Purely combinational N-bit ripple chain of full_adder cells.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  // Per-bit carry nets keep the chain free of self-dependent vectors.
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic ci_s;
    logic co_s;
    if (i == 0) begin : g_first
      assign ci_s = cin_i;
    end else begin : g_next
      assign ci_s = g_bit[i-1].co_s;
    end
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (ci_s),
      .sum_o (sum_o[i]),
      .cout_o(co_s)
    );
  end

  assign cout_o = g_bit[N-1].co_s;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple slices with a
// valid/ready handshake; the final stage register is the output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SLICE  = slice_width(WIDTH, STAGES);
  localparam bit CFG_OK = params_ok(WIDTH, STAGES);
  localparam int LAST   = STAGES - 1;

  if (!CFG_OK) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             advance_s;
  logic             load_out_s;
  logic [WIDTH-1:0] b_op_s;

  // Stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers.
  // Operands are kept right-aligned so each stage adds bits [SLICE-1:0].
  logic [WIDTH-1:0] a_in_s  [STAGES];
  logic [WIDTH-1:0] b_in_s  [STAGES];
  logic [WIDTH-1:0] r_in_s  [STAGES];
  logic             c_in_s  [STAGES];
  logic             v_in_s  [STAGES];
  logic             sa_in_s [STAGES];
  logic             sb_in_s [STAGES];

  logic [SLICE-1:0] s_sum_s  [STAGES];
  logic             s_cout_s [STAGES];

  logic [WIDTH-1:0] a_d  [STAGES];
  logic [WIDTH-1:0] b_d  [STAGES];
  logic [WIDTH-1:0] r_d  [STAGES];
  logic             c_d  [STAGES];
  logic             v_d  [STAGES];
  logic             sa_d [STAGES];
  logic             sb_d [STAGES];
  logic             ovf_d;

  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic             c_q  [STAGES];
  logic             v_q  [STAGES];
  logic             sa_q [STAGES];
  logic             sb_q [STAGES];
  logic             ovf_q;

  assign b_op_s     = Sub ? ~B : B;
  assign advance_s  = out_ready | ~v_q[LAST];
  assign load_out_s = advance_s & v_in_s[LAST];

  // Route each stage's operands, carry, partial result and sign bits.
  always_comb begin
    a_in_s[0]  = A;
    b_in_s[0]  = b_op_s;
    r_in_s[0]  = {WIDTH{1'b0}};
    c_in_s[0]  = Sub ? 1'b1 : Cin;
    v_in_s[0]  = in_valid;
    sa_in_s[0] = A[WIDTH-1];
    sb_in_s[0] = b_op_s[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      a_in_s[k]  = a_q[k-1];
      b_in_s[k]  = b_q[k-1];
      r_in_s[k]  = r_q[k-1];
      c_in_s[k]  = c_q[k-1];
      v_in_s[k]  = v_q[k-1];
      sa_in_s[k] = sa_q[k-1];
      sb_in_s[k] = sb_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(.N(SLICE)) u_slice (
      .a_i   (a_in_s[k][SLICE-1:0]),
      .b_i   (b_in_s[k][SLICE-1:0]),
      .cin_i (c_in_s[k]),
      .sum_o (s_sum_s[k]),
      .cout_o(s_cout_s[k])
    );
  end

  // Each new slice sum enters at the top of the result word, which shifts
  // right, so after the last stage every slice sits at its own position.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]  = a_in_s[k] >> SLICE;
      b_d[k]  = b_in_s[k] >> SLICE;
      r_d[k]  = (r_in_s[k] >> SLICE) | (WIDTH'(s_sum_s[k]) << (WIDTH - SLICE));
      c_d[k]  = s_cout_s[k];
      v_d[k]  = v_in_s[k];
      sa_d[k] = sa_in_s[k];
      sb_d[k] = sb_in_s[k];
    end
    ovf_d = ovf_calc(sa_in_s[LAST], sb_in_s[LAST], s_sum_s[LAST][SLICE-1]);
  end

  // Pipeline registers; the output stage only takes data with a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= {WIDTH{1'b0}};
        b_q[k]  <= {WIDTH{1'b0}};
        r_q[k]  <= {WIDTH{1'b0}};
        c_q[k]  <= 1'b0;
        v_q[k]  <= 1'b0;
        sa_q[k] <= 1'b0;
        sb_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (advance_s) begin
          v_q[k] <= v_d[k];
        end
        if ((k == LAST) ? load_out_s : advance_s) begin
          a_q[k]  <= a_d[k];
          b_q[k]  <= b_d[k];
          r_q[k]  <= r_d[k];
          c_q[k]  <= c_d[k];
          sa_q[k] <= sa_d[k];
          sb_q[k] <= sb_d[k];
        end
      end
      if (load_out_s) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = v_q[LAST];
  assign Sum       = r_q[LAST];
  assign Cout      = c_q[LAST];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4) with directed,
// hand-computed vectors.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = 16'h0000;
  logic [W-1:0] B = 16'h0000;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Cout     (Cout),
    .Ovf      (Ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Present one transaction, hold it until accepted, queue its expectation.
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input logic [W-1:0] es,
                      input logic ec, input logic eo, input bit lat);
    int waited = 0;
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_accept: not accepted within 50 cycles, want accept", tag);
    end else begin
      sb.push_back('{sum: es, cout: ec, ovf: eo, cyc: cyc, lat: lat, tag: tag});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(out_valid), 32'h1);
  endtask

  // Monitor: every accepted output is checked against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out: got Sum=0x%0h with nothing pending, want no out_valid", Sum);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_cout_ovf_sum"}, 32'({Cout, Ovf, Sum}), 32'({e.cout, e.ovf, e.sum}));
        if (e.lat) chk({e.tag, "_latency"}, 32'(cyc - e.cyc), 32'(S));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_sum",       32'(Sum),       32'h0);
    chk("reset_cout",      32'(Cout),      32'h0);
    chk("reset_ovf",       32'(Ovf),       32'h0);
    chk("reset_in_ready",  32'(in_ready),  32'h1);
    @(posedge clk);
    #1 rst = 1'b0;

    send("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();

    send("carry_0fff", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send("ovf_7fff",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send("sub_3_5",    16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    drain();

    send("b2b_0", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
    send("b2b_1", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
    send("b2b_2", 16'h0005, 16'h0006, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b1);
    drain();

    out_ready = 1'b0;
    send("stall_0", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    send("stall_1", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    send("stall_2", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    wait_out_valid("stall_first_valid");
    fork
      send("stall_3", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_sum",       32'(Sum),       32'h0030);
          chk("stall_cout",      32'(Cout),      32'h0);
          chk("stall_ovf",       32'(Ovf),       32'h0);
          chk("stall_in_ready",  32'(in_ready),  32'h0);
          chk("stall_out_valid", 32'(out_valid), 32'h1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send("rst_0", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    send("rst_1", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    wait_out_valid("rst_pre_valid");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'h0);
    chk("rst_async_sum",   32'(Sum),       32'h0);
    chk("rst_async_cout",  32'(Cout),      32'h0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    send("rst_fresh", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
